// File: rtl/yield_accumulator_pkg.sv
// Shared definitions for the yield accumulator.
//   DefaultWidth : default width of argument, yielded values, sum and count
//   state_e      : caller-side FSM states
package yield_accumulator_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StCollect,
        StEmit,
        StDone
    } state_e;

endpackage

// File: rtl/yield_accumulator_if.sv
// Handshake bundle for the yield accumulator.
//   Caller side : n, __start, __ready (to block); __valid, __done, __output_0..2 (from block)
//   Generator   : g_n, g_start, g_ready (from block); g_valid, g_done, g_output (to block)
// slave  : the view used by the accumulator itself
// master : the view used by whatever drives the caller and generator sides
interface yield_accumulator_if
    import yield_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);

    logic [WIDTH-1:0] n;
    logic             __start;
    logic             __ready;
    logic             __valid;
    logic             __done;
    logic [WIDTH-1:0] __output_0;
    logic [WIDTH-1:0] __output_1;
    logic             __output_2;

    logic [WIDTH-1:0] g_n;
    logic             g_start;
    logic             g_ready;
    logic             g_valid;
    logic             g_done;
    logic [WIDTH-1:0] g_output;

    modport slave (
        input  n, __start, __ready, g_valid, g_done, g_output,
        output __valid, __done, __output_0, __output_1, __output_2, g_n, g_start, g_ready
    );

    modport master (
        output n, __start, __ready, g_valid, g_done, g_output,
        input  __valid, __done, __output_0, __output_1, __output_2, g_n, g_start, g_ready
    );

endinterface

// File: rtl/stream_accumulator.sv
// Running sum / count / sticky overflow over a stream of values.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : zero sum, count and overflow (wins over i_enable)
//   i_enable       : accumulate i_data this cycle
//   i_data         : value to add
//   o_sum          : sum modulo 2^WIDTH
//   o_count        : number of accumulated values modulo 2^WIDTH
//   o_overflow     : set once any addition carried out of the sum
module stream_accumulator
    import yield_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic [WIDTH:0]   w_sum_ext;

    // One extra bit to capture the carry-out of the addition.
    assign w_sum_ext = {1'b0, r_sum} + {1'b0, i_data};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_sum      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_enable) begin
            r_sum      <= w_sum_ext[WIDTH-1:0];
            r_count    <= r_count + 1'b1;
            r_overflow <= r_overflow | w_sum_ext[WIDTH];
        end
    end

    assign o_sum      = r_sum;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/yield_accumulator.sv
// Caller/consumer end of a generator handshake: launches the generator with
// argument n, drains every yield into a running sum/count/overflow, then
// offers the aggregate on a valid/ready/done handshake of its own.
//   __clock : clock, all state on rising edge
//   __reset : asynchronous active-low reset
//   bus     : caller and generator handshake signals (slave view)
module yield_accumulator
    import yield_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic          __clock,
    input  logic          __reset,
    yield_accumulator_if.slave bus
);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_g_n;
    logic             r_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic [WIDTH-1:0] r_out_count;
    logic             r_out_overflow;

    logic             w_acc_clear;
    logic             w_acc_enable;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_count;
    logic             w_overflow;

    always_ff @(posedge __clock or negedge __reset) begin
        if (!__reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_clear  = 1'b0;
        w_acc_enable = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.__start) w_state_next = StLaunch;
            end
            StLaunch: begin
                w_acc_clear  = 1'b1;
                w_state_next = StCollect;
            end
            StCollect: begin
                // A yield coincident with g_done is still accumulated.
                w_acc_enable = bus.g_valid;
                if (bus.g_done) w_state_next = StEmit;
            end
            StEmit: begin
                if (r_valid && bus.__ready) w_state_next = StDone;
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Argument capture and result register. Valid rises one cycle after
    // entering StEmit, when the accumulator has absorbed the final yield.
    always_ff @(posedge __clock or negedge __reset) begin
        if (!__reset) begin
            r_g_n          <= '0;
            r_valid        <= 1'b0;
            r_out_sum      <= '0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            if (r_state == StIdle && bus.__start) begin
                r_g_n <= bus.n;
            end
            if (r_state == StEmit) begin
                if (!r_valid) begin
                    r_valid        <= 1'b1;
                    r_out_sum      <= w_sum;
                    r_out_count    <= w_count;
                    r_out_overflow <= w_overflow;
                end else if (bus.__ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    stream_accumulator #(
        .WIDTH (WIDTH)
    ) u_acc (
        .i_clk      (__clock),
        .i_rst_n    (__reset),
        .i_clear    (w_acc_clear),
        .i_enable   (w_acc_enable),
        .i_data     (bus.g_output),
        .o_sum      (w_sum),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    assign bus.g_n        = r_g_n;
    assign bus.g_start    = (r_state == StLaunch);
    assign bus.g_ready    = (r_state == StCollect);
    assign bus.__done     = (r_state == StDone);
    assign bus.__valid    = r_valid;
    assign bus.__output_0 = r_out_sum;
    assign bus.__output_1 = r_out_count;
    assign bus.__output_2 = r_out_overflow;

endmodule

// File: tb/tb_yield_accumulator.sv
// Self-checking bench for yield_accumulator. The bench plays both the caller
// and the generator; expected aggregates go into a scoreboard queue when the
// generator finishes and are compared when the result is accepted.
module tb_yield_accumulator;

    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    yield_accumulator_if #(.WIDTH(W)) bus ();

    yield_accumulator #(.WIDTH(W)) dut (
        .__clock (clk),
        .__reset (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic [W-1:0] cnt;
        logic         ovf;
    } res_t;

    res_t sb_q[$];
    int   n_vec      = 0;
    int   n_err      = 0;
    int   gstart_cnt = 0;
    int   done_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] ys[$]);
        res_t       r;
        logic [W:0] t;
        r = '0;
        foreach (ys[k]) begin
            t     = {1'b0, r.sum} + {1'b0, ys[k]};
            r.sum = t[W-1:0];
            r.ovf = r.ovf | t[W];
            r.cnt = r.cnt + 1'b1;
        end
        return r;
    endfunction

    // Monitor: pulse counting, hold stability, scoreboard pop, done latency.
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic accepted   = 1'b0;
    res_t prev_out   = '0;

    always @(negedge clk) begin
        res_t e;
        if (accepted) check_val("done_latency", 64'(bus.__done), 64'd1);
        accepted = 1'b0;
        if (bus.g_start) gstart_cnt++;
        if (bus.__done) done_cnt++;
        if (bus.__valid && prev_valid && !prev_ready) begin
            check_val("hold_sum", bus.__output_0, prev_out.sum);
            check_val("hold_cnt", bus.__output_1, prev_out.cnt);
            check_val("hold_ovf", 64'(bus.__output_2), 64'(prev_out.ovf));
        end
        if (bus.__valid && bus.__ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("sum", bus.__output_0, e.sum);
                check_val("count", bus.__output_1, e.cnt);
                check_val("overflow", 64'(bus.__output_2), 64'(e.ovf));
            end
            accepted = 1'b1;
        end
        prev_valid = bus.__valid;
        prev_ready = bus.__ready;
        prev_out   = '{sum: bus.__output_0, cnt: bus.__output_1, ovf: bus.__output_2};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold > 0 keeps __ready low for that many cycles after __valid rises.
    task automatic run_call(input logic [W-1:0] arg, input logic [W-1:0] ys[$],
                            input bit coincident, input int hold, input bit poke_start);
        int gs0;
        int dn0;
        bit ok;
        gs0 = gstart_cnt;
        dn0 = done_cnt;
        bus.__ready = (hold == 0);
        bus.n       = arg;
        bus.__start = 1'b1;
        tick();
        bus.__start = 1'b0;
        bus.n       = ~arg;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.g_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_val("launch_seen", 64'(ok), 64'd1);
        check_val("g_n", bus.g_n, arg);
        tick();
        for (int k = 0; k < ys.size(); k++) begin
            ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (bus.g_ready) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            if (!ok) check_val("g_ready_timeout", 64'd0, 64'd1);
            bus.g_valid  = 1'b1;
            bus.g_output = ys[k];
            bus.g_done   = coincident && (k == ys.size() - 1);
            if (poke_start) bus.__start = 1'b1;
            tick();
            bus.g_valid = 1'b0;
            bus.g_done  = 1'b0;
            bus.__start = 1'b0;
        end
        if (!coincident || ys.size() == 0) begin
            bus.g_done = 1'b1;
            tick();
            bus.g_done = 1'b0;
        end
        sb_q.push_back(model(ys));
        check_val("g_ready_off", 64'(bus.g_ready), 64'd0);
        check_val("g_n_hold", bus.g_n, arg);
        // Stray generator activity and start request while emitting.
        bus.g_valid  = 1'b1;
        bus.g_output = 32'h55;
        if (poke_start) bus.__start = 1'b1;
        tick();
        bus.g_valid = 1'b0;
        bus.__start = 1'b0;
        if (hold > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (bus.__valid) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            check_val("valid_seen", 64'(ok), 64'd1);
            for (int i = 0; i < hold; i++) begin
                if (poke_start) bus.__start = 1'b1;
                tick();
            end
            bus.__start = 1'b0;
            bus.__ready = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.__done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_val("done_seen", 64'(ok), 64'd1);
        tick();
        check_val("done_pulses", 64'(done_cnt - dn0), 64'd1);
        check_val("g_start_pulses", 64'(gstart_cnt - gs0), 64'd1);
        check_val("idle_valid", 64'(bus.__valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active, expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ys[$];
        bus.n        = '0;
        bus.__start  = 1'b0;
        bus.__ready  = 1'b0;
        bus.g_valid  = 1'b0;
        bus.g_done   = 1'b0;
        bus.g_output = '0;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_valid", 64'(bus.__valid), 64'd0);
        check_val("rst_done", 64'(bus.__done), 64'd0);
        check_val("rst_out0", bus.__output_0, 64'd0);
        check_val("rst_out1", bus.__output_1, 64'd0);
        check_val("rst_out2", 64'(bus.__output_2), 64'd0);
        check_val("rst_g_start", 64'(bus.g_start), 64'd0);
        check_val("rst_g_ready", 64'(bus.g_ready), 64'd0);
        check_val("rst_g_n", bus.g_n, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic call: 3 + 5 + 7.
        ys = {32'd3, 32'd5, 32'd7};
        run_call(32'd10, ys, 1'b0, 0, 1'b0);

        // Zero-yield call, with stray generator strobes while idle.
        bus.g_valid  = 1'b1;
        bus.g_done   = 1'b1;
        bus.g_output = 32'd100;
        tick();
        bus.g_valid = 1'b0;
        bus.g_done  = 1'b0;
        ys.delete();
        run_call(32'd4, ys, 1'b0, 0, 1'b0);

        // Wrap with sticky overflow.
        ys = {32'hFFFF_FFFF, 32'd2};
        run_call(32'hA5A5_0001, ys, 1'b0, 0, 1'b0);

        // Final yield coincident with g_done.
        ys = {32'd6, 32'd4};
        run_call(32'd2, ys, 1'b1, 0, 1'b0);

        // Backpressure for 5 cycles, with start requests during collect/emit.
        ys = {32'd11, 32'd22, 32'd33};
        run_call(32'd77, ys, 1'b0, 5, 1'b1);

        // Overflow cleared between calls, long stream.
        ys = {32'h8000_0000, 32'h8000_0000, 32'd1, 32'd2, 32'd3};
        run_call(32'd5, ys, 1'b1, 2, 1'b0);

        // Reset in the middle of collecting.
        bus.__ready = 1'b1;
        bus.n       = 32'd7;
        bus.__start = 1'b1;
        tick();
        bus.__start = 1'b0;
        tick();
        bus.g_valid  = 1'b1;
        bus.g_output = 32'd1;
        tick();
        bus.g_output = 32'd2;
        tick();
        bus.g_valid = 1'b0;
        check_val("pre_rst_collect", 64'(bus.g_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(bus.__valid), 64'd0);
        check_val("mid_rst_done", 64'(bus.__done), 64'd0);
        check_val("mid_rst_out0", bus.__output_0, 64'd0);
        check_val("mid_rst_out1", bus.__output_1, 64'd0);
        check_val("mid_rst_out2", 64'(bus.__output_2), 64'd0);
        check_val("mid_rst_g_start", 64'(bus.g_start), 64'd0);
        check_val("mid_rst_g_ready", 64'(bus.g_ready), 64'd0);
        check_val("mid_rst_g_n", bus.g_n, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("sb_clean", 64'(sb_q.size()), 64'd0);
        ys = {32'd9};
        run_call(32'd3, ys, 1'b0, 0, 1'b0);

        tick();
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
